// File: rtl/kernel_ad_cnt_pio.sv
// kernel_ad_cnt_pio: multi-channel Avalon-MM output register block with set/clear, tick counters and change strobes
module kernel_ad_cnt_pio #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter int ADDR_W = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [CHANNELS-1:0]       cnt_tick,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic [CHANNELS-1:0]       out_strobe
);
  localparam int CW = ADDR_W - 2;
  logic wr;
  logic [CW-1:0] ch;
  logic [1:0] sel;
  logic [WIDTH-1:0] wd;
  logic [31:0] rd [CHANNELS];
  logic unused_wd;
  assign wr = chipselect & ~write_n;
  assign ch = address[ADDR_W-1:2];
  assign sel = address[1:0];
  assign wd = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] data, data_d;
    logic cnt_en, sat, ovf, strobe, hit, bus_wr, ctrl_wr, inc, top;
    assign hit = wr && ch == CW'(n);
    assign bus_wr = hit && sel != 2'd3;
    assign ctrl_wr = hit && sel == 2'd3;
    assign top = &data;
    // a data-path bus write drops any coincident tick
    assign inc = cnt_en && cnt_tick[n] && !bus_wr;
    always_comb begin
      data_d = bus_wr ? (sel == 2'd0 ? wd : sel == 2'd1 ? data | wd : data & ~wd)
             : inc ? (top ? (sat ? data : '0) : data + WIDTH'(1))
             : data;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data <= RESET_VAL;
        cnt_en <= 1'b0;
        sat <= 1'b0;
        ovf <= 1'b0;
        strobe <= 1'b0;
      end else begin
        data <= data_d;
        strobe <= data_d != data;
        ovf <= (inc && top) || (ovf && !(ctrl_wr && writedata[2]));
        if (ctrl_wr) begin
          cnt_en <= writedata[0];
          sat <= writedata[1];
        end
      end
    end
    assign out_port[n*WIDTH +: WIDTH] = data;
    assign out_strobe[n] = strobe;
    assign rd[n] = sel == 2'd0 ? 32'(data) : sel == 2'd3 ? {29'd0, ovf, sat, cnt_en} : 32'd0;
  end
  always_comb begin
    readdata = '0;
    for (int i = 0; i < CHANNELS; i++) readdata = ch == CW'(i) ? rd[i] : readdata;
  end
endmodule
